// File: rtl/alu_md_control.sv
// ALU operation decode plus an iterative HI/LO multiply/divide unit.
// Define ALU_MD_FAST_MUL_EN to complete MULT/MULTU in one cycle on a full-width multiplier.
module alu_md_control #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ALU_OP_D,
  input  logic [5:0]        Funct,
  input  logic              valid_D,
  input  logic              flush,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [3:0]        ALU_Instruction_D,
  output logic              md_stall,
  output logic              md_done,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [DATA_W-1:0]   acc_hi, acc_hi_d, acc_lo, acc_lo_d, opb, opb_d;
  logic                is_div, is_div_d, neg_q, neg_q_d, neg_r, neg_r_d, div0, div0_d;
  logic [DATA_W-1:0]   hi_d, lo_d;
  logic                done_d, md_start;

  logic                hilo_funct, md_req, accept, is_signed, a_neg, b_neg;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     mul_sum, div_sh;
  logic                div_ge;
  logic [2*DATA_W-1:0] prod_mag;

  // ALU operation decode
  always_comb begin
    ALU_Instruction_D = 4'b1111;
    case (ALU_OP_D)
      3'b000: ALU_Instruction_D = 4'b0010;
      3'b001: ALU_Instruction_D = 4'b0110;
      3'b011: ALU_Instruction_D = 4'b0000;
      3'b100: ALU_Instruction_D = 4'b0001;
      3'b101: ALU_Instruction_D = 4'b0111;
      3'b110: ALU_Instruction_D = 4'b1001;
      3'b111: ALU_Instruction_D = 4'b1101;
      3'b010: begin
        case (Funct)
          F_ADD:   ALU_Instruction_D = 4'b0010;
          F_SUB:   ALU_Instruction_D = 4'b0110;
          F_AND:   ALU_Instruction_D = 4'b0000;
          F_OR:    ALU_Instruction_D = 4'b0001;
          F_NOR:   ALU_Instruction_D = 4'b1100;
          F_XOR:   ALU_Instruction_D = 4'b1101;
          F_SLL:   ALU_Instruction_D = 4'b0100;
          F_SLT:   ALU_Instruction_D = 4'b0111;
          F_SRA:   ALU_Instruction_D = 4'b0101;
          F_SRL:   ALU_Instruction_D = 4'b1000;
          F_MFHI:  ALU_Instruction_D = 4'b1010;
          F_MFLO:  ALU_Instruction_D = 4'b1011;
          F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO:
                   ALU_Instruction_D = 4'b1110;
          default: ALU_Instruction_D = 4'b1111;
        endcase
      end
      default: ALU_Instruction_D = 4'b1111;
    endcase
  end

  always_comb begin
    hilo_funct = 1'b0;
    case (Funct)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: hilo_funct = 1'b1;
      default: hilo_funct = 1'b0;
    endcase
  end

  assign md_req   = valid_D && !flush && (ALU_OP_D == 3'b010) && hilo_funct;
  assign md_stall = md_req && (state != IDLE);
  assign accept   = md_req && (state == IDLE);

  // Signed ops (MULT/DIV) have Funct[0]=0; the iteration runs on magnitudes.
  assign is_signed = ~Funct[0];
  assign a_neg     = is_signed & rs_val[DATA_W-1];
  assign b_neg     = is_signed & rt_val[DATA_W-1];
  assign mag_a     = a_neg ? -rs_val : rs_val;
  assign mag_b     = b_neg ? -rt_val : rt_val;

  assign mul_sum  = {1'b0, acc_hi} + {1'b0, opb & {DATA_W{acc_lo[0]}}};
  assign div_sh   = {acc_hi, acc_lo[DATA_W-1]};
  assign div_ge   = div_sh >= {1'b0, opb};
  assign prod_mag = {acc_hi, acc_lo};

`ifdef ALU_MD_FAST_MUL_EN
  logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{DATA_W{a_neg}}, rs_val};
  assign ext_b     = {{DATA_W{b_neg}}, rt_val};
  assign fast_prod = ext_a * ext_b;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    acc_hi_d = acc_hi;
    acc_lo_d = acc_lo;
    opb_d    = opb;
    is_div_d = is_div;
    neg_q_d  = neg_q;
    neg_r_d  = neg_r;
    div0_d   = div0;
    hi_d     = hi_out;
    lo_d     = lo_out;
    done_d   = 1'b0;
    md_start = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (Funct)
            F_MTHI: hi_d = rs_val;
            F_MTLO: lo_d = rs_val;
            F_MULT, F_MULTU: begin
`ifdef ALU_MD_FAST_MUL_EN
              {hi_d, lo_d} = fast_prod;
              done_d       = 1'b1;
`else
              md_start = 1'b1;
`endif
            end
            F_DIV, F_DIVU: md_start = 1'b1;
            default: ;
          endcase
        end
        if (md_start) begin
          state_d  = BUSY;
          cnt_d    = CNT_W'(DATA_W - 1);
          acc_hi_d = '0;
          acc_lo_d = mag_a;
          opb_d    = mag_b;
          is_div_d = Funct[1];
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          div0_d   = (rt_val == '0);
        end
      end
      BUSY: begin
        if (is_div) begin
          acc_hi_d = div_ge ? (div_sh[DATA_W-1:0] - opb) : div_sh[DATA_W-1:0];
          acc_lo_d = {acc_lo[DATA_W-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[DATA_W:1];
          acc_lo_d = {mul_sum[0], acc_lo[DATA_W-1:1]};
        end
        if (cnt == '0) state_d = FIX;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      FIX: begin
        // Divide-by-zero leaves |dividend| as remainder, so sign fix restores the dividend.
        if (is_div) begin
          hi_d = neg_r ? -acc_hi : acc_hi;
          lo_d = div0 ? '1 : (neg_q ? -acc_lo : acc_lo);
        end else begin
          {hi_d, lo_d} = neg_q ? -prod_mag : prod_mag;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      acc_hi  <= acc_hi_d;
      acc_lo  <= acc_lo_d;
      opb     <= opb_d;
      is_div  <= is_div_d;
      neg_q   <= neg_q_d;
      neg_r   <= neg_r_d;
      div0    <= div0_d;
      hi_out  <= hi_d;
      lo_out  <= lo_d;
      md_done <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_md_control.sv
// Directed self-checking bench for alu_md_control at DATA_W=32.
module tb_alu_md_control;

`ifdef ALU_MD_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  ALU_OP_D = 3'b000;
  logic [5:0]  Funct = 6'b100000;
  logic        valid_D = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [3:0]  ALU_Instruction_D;
  logic        md_stall, md_done;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;

  alu_md_control #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALU_OP_D(ALU_OP_D), .Funct(Funct),
    .valid_D(valid_D), .flush(flush), .rs_val(rs_val), .rt_val(rt_val),
    .ALU_Instruction_D(ALU_Instruction_D), .md_stall(md_stall), .md_done(md_done),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    ALU_OP_D = 3'b010; Funct = f; rs_val = a; rt_val = b; valid_D = 1'b1;
    @(posedge clk); #1;
    valid_D = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!md_done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (hi_out !== 32'h0) begin $display("FAIL reset_hi got=%h exp=0", hi_out); failures++; end
    checks++; if (lo_out !== 32'h0) begin $display("FAIL reset_lo got=%h exp=0", lo_out); failures++; end
    checks++; if (md_done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", md_done); failures++; end
    checks++; if (md_stall !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", md_stall); failures++; end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_decode;
    logic [2:0] ops [22] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111,
                             3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
                             3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    logic [5:0] fns [22] = '{6'b100010, 6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000, 6'b100000,
                             6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b100110, 6'b000000,
                             6'b101010, 6'b000011, 6'b000010, F_MFHI, F_MFLO, F_MULT, F_DIVU, 6'b100001};
    logic [3:0] exps [22] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1001, 4'b1101,
                              4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b1101, 4'b0100,
                              4'b0111, 4'b0101, 4'b1000, 4'b1010, 4'b1011, 4'b1110, 4'b1110, 4'b1111};
    for (int i = 0; i < 22; i++) begin
      ALU_OP_D = ops[i]; Funct = fns[i];
      #1;
      checks++;
      if (ALU_Instruction_D !== exps[i]) begin
        $display("FAIL decode[%0d] op=%b funct=%b got=%b exp=%b", i, ops[i], fns[i], ALU_Instruction_D, exps[i]);
        failures++;
      end
    end
    ALU_OP_D = 3'b010; Funct = F_MTLO; #1;
    checks++; if (ALU_Instruction_D !== 4'b1110) begin $display("FAIL decode_mtlo got=%b exp=1110", ALU_Instruction_D); failures++; end
    ALU_OP_D = 3'b010; Funct = 6'b100010; valid_D = 1'b1; #1;
    checks++; if (ALU_Instruction_D !== 4'b0110) begin $display("FAIL decode_sub got=%b exp=0110", ALU_Instruction_D); failures++; end
    checks++; if (md_stall !== 1'b0) begin $display("FAIL sub_stall got=%b exp=0", md_stall); failures++; end
    valid_D = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    logic [5:0]  fn [4] = '{F_MULT, F_MULTU, F_MULT, F_MULT};
    logic [31:0] av [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000};
    logic [31:0] bv [4] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
    logic [31:0] eh [4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h40000000};
    logic [31:0] el [4] = '{32'hFFFFFFEB, 32'h00000001, 32'h0000000F, 32'h0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(fn[i], av[i], bv[i]);
      wait_done(lat);
      checks++; if (lat !== MUL_LAT) begin $display("FAIL mul_lat[%0d] got=%0d exp=%0d", i, lat, MUL_LAT); failures++; end
      checks++; if (hi_out !== eh[i]) begin $display("FAIL mul_hi[%0d] got=%h exp=%h", i, hi_out, eh[i]); failures++; end
      checks++; if (lo_out !== el[i]) begin $display("FAIL mul_lo[%0d] got=%h exp=%h", i, lo_out, el[i]); failures++; end
      @(posedge clk); #1;
      checks++; if (md_done !== 1'b0) begin $display("FAIL mul_pulse[%0d] got=%b exp=0", i, md_done); failures++; end
    end
  endtask

  task automatic test_div;
    logic [5:0]  fn [8] = '{F_DIVU, F_DIV, F_DIV, F_DIV, F_DIV, F_DIV, F_DIVU, F_DIVU};
    logic [31:0] av [8] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'd5, 32'hFFFFFFFB,
                            32'h80000000, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bv [8] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'd0, 32'd0,
                            32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
    logic [31:0] eh [8] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'd5, 32'hFFFFFFFB,
                            32'h0, 32'h80000000, 32'h0};
    logic [31:0] el [8] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h80000000, 32'h0, 32'hFFFFFFFF};
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue(fn[i], av[i], bv[i]);
      wait_done(lat);
      checks++; if (lat !== DIV_LAT) begin $display("FAIL div_lat[%0d] got=%0d exp=%0d", i, lat, DIV_LAT); failures++; end
      checks++; if (hi_out !== eh[i]) begin $display("FAIL div_hi[%0d] got=%h exp=%h", i, hi_out, eh[i]); failures++; end
      checks++; if (lo_out !== el[i]) begin $display("FAIL div_lo[%0d] got=%h exp=%h", i, lo_out, el[i]); failures++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mthi_mtlo;
    issue(F_MTHI, 32'h12345678, 32'h0);
    checks++; if (hi_out !== 32'h12345678) begin $display("FAIL mthi got=%h exp=12345678", hi_out); failures++; end
    checks++; if (md_done !== 1'b0) begin $display("FAIL mthi_done got=%b exp=0", md_done); failures++; end
    issue(F_MTLO, 32'h9ABCDEF0, 32'h0);
    checks++; if (lo_out !== 32'h9ABCDEF0) begin $display("FAIL mtlo got=%h exp=9abcdef0", lo_out); failures++; end
    checks++; if (hi_out !== 32'h12345678) begin $display("FAIL mtlo_hi got=%h exp=12345678", hi_out); failures++; end
    flush = 1'b1;
    issue(F_MTHI, 32'hDEADBEEF, 32'h0);
    flush = 1'b0;
    checks++; if (hi_out !== 32'h12345678) begin $display("FAIL flushed_mthi got=%h exp=12345678", hi_out); failures++; end
    Funct = F_MFHI; valid_D = 1'b1; #1;
    checks++; if (md_stall !== 1'b0) begin $display("FAIL mfhi_idle_stall got=%b exp=0", md_stall); failures++; end
    valid_D = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mflo_stall;
    int stall_cnt = 0;
    issue(F_DIVU, 32'd1000, 32'd10);
    Funct = F_MFLO; valid_D = 1'b1; #1;
    while (md_stall && stall_cnt < 100) begin
      stall_cnt++;
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt !== 33) begin $display("FAIL mflo_stall_cycles got=%0d exp=33", stall_cnt); failures++; end
    checks++; if (md_done !== 1'b1) begin $display("FAIL mflo_done got=%b exp=1", md_done); failures++; end
    checks++; if (ALU_Instruction_D !== 4'b1011) begin $display("FAIL mflo_decode got=%b exp=1011", ALU_Instruction_D); failures++; end
    checks++; if (lo_out !== 32'd100) begin $display("FAIL mflo_value got=%h exp=64", lo_out); failures++; end
    valid_D = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int stall_cnt = 0;
    int lat;
    issue(F_DIVU, 32'd100, 32'd7);
    Funct = F_MULTU; rs_val = 32'd6; rt_val = 32'd7; valid_D = 1'b1; #1;
    while (md_stall && stall_cnt < 100) begin
      stall_cnt++;
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt !== 33) begin $display("FAIL b2b_stall_cycles got=%0d exp=33", stall_cnt); failures++; end
    checks++; if (lo_out !== 32'd14) begin $display("FAIL b2b_first_lo got=%h exp=e", lo_out); failures++; end
    @(posedge clk); #1;
    valid_D = 1'b0;
    wait_done(lat);
    checks++; if (lat !== MUL_LAT) begin $display("FAIL b2b_lat got=%0d exp=%0d", lat, MUL_LAT); failures++; end
    checks++; if (lo_out !== 32'd42) begin $display("FAIL b2b_lo got=%h exp=2a", lo_out); failures++; end
    checks++; if (hi_out !== 32'd0) begin $display("FAIL b2b_hi got=%h exp=0", hi_out); failures++; end
    @(posedge clk); #1;
  endtask

  task automatic test_latch;
    int lat;
    issue(F_DIV, 32'hFFFFFF9C, 32'd7);
    Funct = F_DIV; rs_val = 32'd5; rt_val = 32'd0; flush = 1'b1; valid_D = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    valid_D = 1'b0; flush = 1'b0;
    wait_done(lat);
    checks++; if (lat + 5 !== DIV_LAT) begin $display("FAIL latch_lat got=%0d exp=%0d", lat + 5, DIV_LAT); failures++; end
    checks++; if (hi_out !== 32'hFFFFFFFE) begin $display("FAIL latch_hi got=%h exp=fffffffe", hi_out); failures++; end
    checks++; if (lo_out !== 32'hFFFFFFF2) begin $display("FAIL latch_lo got=%h exp=fffffff2", lo_out); failures++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic seen_done = 1'b0;
    issue(F_DIVU, 32'd100, 32'd7);
    Funct = F_MFLO; valid_D = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    checks++; if (md_stall !== 1'b1) begin $display("FAIL midrst_pre_stall got=%b exp=1", md_stall); failures++; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hi_out !== 32'h0) begin $display("FAIL midrst_hi got=%h exp=0", hi_out); failures++; end
    checks++; if (lo_out !== 32'h0) begin $display("FAIL midrst_lo got=%h exp=0", lo_out); failures++; end
    checks++; if (md_stall !== 1'b0) begin $display("FAIL midrst_stall got=%b exp=0", md_stall); failures++; end
    #1 rst_n = 1'b1;
    Funct = F_MTHI; rs_val = 32'h0000A5A5; valid_D = 1'b1;
    @(posedge clk); #1;
    valid_D = 1'b0;
    checks++; if (hi_out !== 32'h0000A5A5) begin $display("FAIL post_rst_accept got=%h exp=0000a5a5", hi_out); failures++; end
    checks++; if (lo_out !== 32'h0) begin $display("FAIL post_rst_lo got=%h exp=0", lo_out); failures++; end
    for (int i = 0; i < 40; i++) begin
      if (md_done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen_done !== 1'b0) begin $display("FAIL midrst_no_done got=%b exp=0", seen_done); failures++; end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_mflo_stall();
    test_back_to_back();
    test_latch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
